// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite initiator and its stall timer.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Accelerator register map: run/matw/last word and control word.
  localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
  localparam logic [31:0] REG_CONTROL = 32'h0000_0010;

  // Counter width able to hold max_count; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle; the initiator uses the master modport, the slave the other.
interface axil_master_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_stall_timer.sv
// Counts cycles spent waiting on the bus; raises a sticky flag once the limit is hit.
module axil_stall_timer
  import axil_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int              CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    // NOTE: every signal assigned here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (TIMEOUT != 0) && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
      if (count_d == LIMIT) timeout_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command becomes one
// register write or read; result returns on a valid/ready response channel.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,

  output logic              timeout,

  axil_master_if.master     m_axi
);

  // Every bus-facing output is a flop in this bundle.
  typedef struct packed {
    logic              awvalid;
    logic              wvalid;
    logic              bready;
    logic              arvalid;
    logic              rready;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              rsp_valid;
    logic              rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
  } regs_t;

  state_e state_q, state_d;
  regs_t  r_q, r_d;

  logic aw_hs, w_hs, ar_hs;
  logic stall_clear, stall_enable;

  assign aw_hs = r_q.awvalid & m_axi.awready;
  assign w_hs  = r_q.wvalid  & m_axi.wready;
  assign ar_hs = r_q.arvalid & m_axi.arready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          r_d.addr = cmd_addr;
          if (cmd_write) begin
            r_d.wdata   = cmd_wdata;
            r_d.wstrb   = cmd_wstrb;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
            r_d.aw_done = 1'b0;
            r_d.w_done  = 1'b0;
            state_d     = WADDR;
          end else begin
            r_d.arvalid = 1'b1;
            state_d     = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W complete independently, in either order.
        if (aw_hs) begin
          r_d.awvalid = 1'b0;
          r_d.aw_done = 1'b1;
        end
        if (w_hs) begin
          r_d.wvalid = 1'b0;
          r_d.w_done = 1'b1;
        end
        if (r_d.aw_done && r_d.w_done) begin
          r_d.aw_done = 1'b0;
          r_d.w_done  = 1'b0;
          r_d.bready  = 1'b1;
          state_d     = WRESP;
        end
      end
      WRESP: begin
        if (m_axi.bvalid) begin
          r_d.bready    = 1'b0;
          r_d.rsp_valid = 1'b1;
          r_d.rsp_write = 1'b1;
          r_d.rsp_rdata = '0;
          r_d.rsp_resp  = m_axi.bresp;
          state_d       = RSP;
        end
      end
      RADDR: begin
        if (ar_hs) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
          state_d     = RDATA;
        end
      end
      RDATA: begin
        if (m_axi.rvalid) begin
          r_d.rready    = 1'b0;
          r_d.rsp_valid = 1'b1;
          r_d.rsp_write = 1'b0;
          r_d.rsp_rdata = m_axi.rdata;
          r_d.rsp_resp  = m_axi.rresp;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          r_d.rsp_valid = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  // The stall window restarts on every state change and runs only while waiting on the slave.
  assign stall_clear  = (state_d != state_q);
  assign stall_enable = (state_q == WADDR) || (state_q == WRESP) ||
                        (state_q == RADDR) || (state_q == RDATA);

  axil_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear   (stall_clear),
    .enable  (stall_enable),
    .timeout (timeout)
  );

  assign cmd_ready = (state_q == IDLE);

  assign rsp_valid = r_q.rsp_valid;
  assign rsp_write = r_q.rsp_write;
  assign rsp_rdata = r_q.rsp_rdata;
  assign rsp_resp  = r_q.rsp_resp;

  assign m_axi.awaddr  = r_q.addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_q.awvalid;
  assign m_axi.wdata   = r_q.wdata;
  assign m_axi.wstrb   = r_q.wstrb;
  assign m_axi.wvalid  = r_q.wvalid;
  assign m_axi.bready  = r_q.bready;
  assign m_axi.araddr  = r_q.addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_q.arvalid;
  assign m_axi.rready  = r_q.rready;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master against a small accelerator-register slave
// with knobs for AW delay, muted B, held ARREADY and forced read responses.
module tb_axil_master;
  import axil_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_write;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              timeout;

  int checks = 0;
  int errors = 0;

  axil_master_if #(.ADDR_W(ADDR_W)) m_axi ();

  axil_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .timeout       (timeout),
    .m_axi         (m_axi)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  bit          b_mute = 1'b0, ar_hold = 1'b0, r_force = 1'b0;
  logic [31:0] r_force_data = '0;
  logic [1:0]  r_force_resp = RESP_OKAY;

  logic        aw_got, w_got, b_pend, r_busy;
  int          aw_cnt;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  logic [2:0]  ctrl_reg;     // {last, run, matw}
  logic [31:0] control_reg;

  logic        s_aw_hs, s_w_hs, s_ar_hs;
  logic [31:0] eff_addr, eff_data;
  logic [3:0]  eff_strb;

  assign m_axi.awready = !aw_got && (aw_cnt >= aw_delay);
  assign m_axi.wready  = !w_got;
  assign m_axi.arready = !r_busy && !ar_hold;
  assign m_axi.bresp   = RESP_OKAY;

  assign s_aw_hs  = m_axi.awvalid && m_axi.awready;
  assign s_w_hs   = m_axi.wvalid && m_axi.wready;
  assign s_ar_hs  = m_axi.arvalid && m_axi.arready;
  assign eff_addr = s_aw_hs ? m_axi.awaddr : aw_addr_l;
  assign eff_data = s_w_hs ? m_axi.wdata : w_data_l;
  assign eff_strb = s_w_hs ? m_axi.wstrb : w_strb_l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_busy <= 1'b0; aw_cnt <= 0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
      ctrl_reg <= '0; control_reg <= '0;
      m_axi.bvalid <= 1'b0; m_axi.rvalid <= 1'b0;
      m_axi.rdata <= '0; m_axi.rresp <= RESP_OKAY;
    end else begin
      if (m_axi.awvalid && !aw_got && !m_axi.awready) aw_cnt <= aw_cnt + 1;
      if (s_aw_hs) begin aw_got <= 1'b1; aw_addr_l <= m_axi.awaddr; end
      if (s_w_hs) begin w_got <= 1'b1; w_data_l <= m_axi.wdata; w_strb_l <= m_axi.wstrb; end
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
        if (eff_addr == REG_CTRL && eff_strb[0]) ctrl_reg <= eff_data[2:0];
        if (eff_addr == REG_CONTROL)
          for (int b = 0; b < 4; b++)
            if (eff_strb[b]) control_reg[8*b +: 8] <= eff_data[8*b +: 8];
        if (b_mute) b_pend <= 1'b1;
        else        m_axi.bvalid <= 1'b1;
      end
      if (b_pend && !b_mute) begin m_axi.bvalid <= 1'b1; b_pend <= 1'b0; end
      if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;
      if (s_ar_hs) begin
        r_busy       <= 1'b1;
        m_axi.rvalid <= 1'b1;
        m_axi.rresp  <= r_force ? r_force_resp : RESP_OKAY;
        m_axi.rdata  <= r_force ? r_force_data :
                        (m_axi.araddr == REG_CONTROL) ? control_reg :
                        (m_axi.araddr == REG_CTRL) ? {29'b0, ctrl_reg} : 32'h0;
      end
      if (m_axi.rvalid && m_axi.rready) begin m_axi.rvalid <= 1'b0; r_busy <= 1'b0; end
    end
  end

  // ---------------- bus monitor (samples at the active edge) ----------------
  int mon_cyc = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hi_n = 0;
  int aw_stall_n = 0, w_hi_n = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

  always @(posedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (rst_n) begin
      if (m_axi.awvalid && m_axi.awready) begin aw_hs_n <= aw_hs_n + 1; aw_hs_cyc <= mon_cyc; end
      if (m_axi.wvalid && m_axi.wready) begin w_hs_n <= w_hs_n + 1; w_hs_cyc <= mon_cyc; end
      if (m_axi.bvalid && m_axi.bready) b_hs_n <= b_hs_n + 1;
      if (m_axi.arvalid) ar_hi_n <= ar_hi_n + 1;
      if (m_axi.awvalid && !m_axi.awready) aw_stall_n <= aw_stall_n + 1;
      if (m_axi.wvalid) w_hi_n <= w_hi_n + 1;
    end
  end

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    // Junk on the idle command bus must be ignored.
    cmd_valid = 1'b0; cmd_write = 1'b1; cmd_addr = 32'hFFFF_FFFC;
    cmd_wdata = 32'hBAD0_BAD0; cmd_wstrb = 4'hF;
  endtask

  task automatic wait_rsp(output bit got, output int cycles);
    got = 1'b0;
    cycles = 1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else begin @(negedge clk); cycles++; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_axi_valids: got %b expected 00000",
               {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready});
    end
    checks++;
    if ({rsp_valid, timeout, rsp_write, rsp_resp, rsp_rdata} !== 37'b0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b timeout=%b write=%b resp=%b rdata=%h expected all 0",
               rsp_valid, timeout, rsp_write, rsp_resp, rsp_rdata);
    end
    checks++;
    if ({m_axi.awaddr, m_axi.wdata, m_axi.wstrb} !== 68'b0) begin
      errors++;
      $display("FAIL reset_addr_data: awaddr=%h wdata=%h wstrb=%h expected 0",
               m_axi.awaddr, m_axi.wdata, m_axi.wstrb);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write_ctrl;
    bit ok, got; int cyc; int aw0, w0;
    rsp_ready = 1'b1; aw0 = aw_hs_n; w0 = w_hs_n;
    send_cmd(1'b1, REG_CTRL, 32'h0000_0007, 4'hF, ok);
    wait_rsp(got, cyc);
    checks++;
    if (!(ok && got)) begin
      errors++; $display("FAIL wr_ctrl_done: accepted=%b responded=%b expected 1/1", ok, got);
    end
    checks++;
    if (cyc !== 3) begin
      errors++; $display("FAIL wr_ctrl_latency: got %0d cycles expected 3", cyc);
    end
    checks++;
    if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, RESP_OKAY, 32'h0}) begin
      errors++;
      $display("FAIL wr_ctrl_rsp: write=%b resp=%b rdata=%h expected 1/00/00000000",
               rsp_write, rsp_resp, rsp_rdata);
    end
    checks++;
    if ({m_axi.awprot, m_axi.arprot} !== 6'b0) begin
      errors++; $display("FAIL wr_ctrl_prot: got %b expected 000000", {m_axi.awprot, m_axi.arprot});
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL wr_ctrl_idle_t4: cmd_ready/rsp_valid=%b expected 10", {cmd_ready, rsp_valid});
    end
    checks++;
    if ((aw_hs_n - aw0) != 1 || (w_hs_n - w0) != 1 || aw_hs_cyc != w_hs_cyc) begin
      errors++;
      $display("FAIL wr_ctrl_same_cycle: aw=%0d w=%0d aw_cyc=%0d w_cyc=%0d expected 1/1/equal",
               aw_hs_n - aw0, w_hs_n - w0, aw_hs_cyc, w_hs_cyc);
    end
    checks++;
    if (ctrl_reg !== 3'b111) begin
      errors++; $display("FAIL wr_ctrl_slave_reg: got %b expected 111", ctrl_reg);
    end
  endtask

  task automatic test_write_read;
    bit ok, got; int cyc; int ar0;
    rsp_ready = 1'b1;
    send_cmd(1'b1, REG_CONTROL, 32'hDEAD_BEEF, 4'hF, ok);
    wait_rsp(got, cyc);
    checks++;
    if (!(ok && got) || rsp_resp !== RESP_OKAY) begin
      errors++; $display("FAIL wr_control: done=%b resp=%b expected 1/00", ok && got, rsp_resp);
    end
    ar0 = ar_hi_n;
    send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, ok);
    wait_rsp(got, cyc);
    checks++;
    if (!(ok && got) || cyc !== 3) begin
      errors++; $display("FAIL rd_control_latency: done=%b cycles=%0d expected 1/3", ok && got, cyc);
    end
    checks++;
    if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b0, RESP_OKAY, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL rd_control_rsp: write=%b resp=%b rdata=%h expected 0/00/deadbeef",
               rsp_write, rsp_resp, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if ((ar_hi_n - ar0) != 1) begin
      errors++; $display("FAIL rd_arvalid_width: got %0d cycles expected 1", ar_hi_n - ar0);
    end
  endtask

  task automatic test_aw_stall;
    bit ok, got; int cyc; int aw0, b0, st0, wh0;
    rsp_ready = 1'b1; aw_delay = 5;
    aw0 = aw_hs_n; b0 = b_hs_n; st0 = aw_stall_n; wh0 = w_hi_n;
    send_cmd(1'b1, REG_CONTROL, 32'h0000_00A5, 4'b0001, ok);
    wait_rsp(got, cyc);
    checks++;
    if (!(ok && got) || {rsp_write, rsp_resp} !== {1'b1, RESP_OKAY}) begin
      errors++;
      $display("FAIL aw_stall_rsp: done=%b write=%b resp=%b expected 1/1/00", ok && got, rsp_write, rsp_resp);
    end
    @(negedge clk);
    aw_delay = 0;
    checks++;
    if ((aw_stall_n - st0) != 5 || (aw_hs_n - aw0) != 1) begin
      errors++;
      $display("FAIL aw_stall_cycles: stalled=%0d handshakes=%0d expected 5/1", aw_stall_n - st0, aw_hs_n - aw0);
    end
    checks++;
    if (!(w_hs_cyc < aw_hs_cyc) || (w_hi_n - wh0) != 1) begin
      errors++;
      $display("FAIL aw_stall_w_first: w_cyc=%0d aw_cyc=%0d wvalid_cycles=%0d expected w<aw and 1",
               w_hs_cyc, aw_hs_cyc, w_hi_n - wh0);
    end
    checks++;
    if ((b_hs_n - b0) != 1) begin
      errors++; $display("FAIL aw_stall_single_b: got %0d expected 1", b_hs_n - b0);
    end
    checks++;
    if (control_reg !== 32'hDEAD_BEA5) begin
      errors++; $display("FAIL aw_stall_strobe: got %h expected deadbea5", control_reg);
    end
  endtask

  task automatic test_read_error;
    bit ok, got; int cyc;
    r_force = 1'b1; r_force_data = 32'h1234_5678; r_force_resp = RESP_SLVERR;
    rsp_ready = 1'b0;
    send_cmd(1'b0, REG_CTRL, 32'h0, 4'h0, ok);
    wait_rsp(got, cyc);
    checks++;
    if (!(ok && got)) begin
      errors++; $display("FAIL rd_err_done: accepted=%b responded=%b expected 1/1", ok, got);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata} !==
          {1'b1, 1'b0, 1'b0, RESP_SLVERR, 32'h1234_5678}) begin
        errors++;
        $display("FAIL rd_err_hold[%0d]: valid=%b cmd_ready=%b write=%b resp=%b rdata=%h expected 1/0/0/10/12345678",
                 i, rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    r_force = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_err_accept: valid/cmd_ready=%b expected 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_timeout;
    bit ok, got; int cyc;
    rsp_ready = 1'b1; b_mute = 1'b1;
    send_cmd(1'b1, REG_CTRL, 32'h0000_0001, 4'hF, ok);
    // Now in cycle 1 (WADDR); WRESP is entered at the end of it.
    repeat (16) @(negedge clk);
    checks++;
    if (!ok || {timeout, m_axi.bready} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_before: accepted=%b timeout=%b bready=%b expected 1/0/1", ok, timeout, m_axi.bready);
    end
    @(negedge clk);
    checks++;
    if ({timeout, m_axi.bready, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_at_16: timeout=%b bready=%b rsp_valid=%b expected 1/1/0",
               timeout, m_axi.bready, rsp_valid);
    end
    b_mute = 1'b0;
    wait_rsp(got, cyc);
    checks++;
    if (!got || {timeout, rsp_write, rsp_resp} !== {1'b1, 1'b1, RESP_OKAY}) begin
      errors++;
      $display("FAIL timeout_late_b: done=%b timeout=%b write=%b resp=%b expected 1/1/1/00",
               got, timeout, rsp_write, rsp_resp);
    end
  endtask

  task automatic test_reset_mid_read;
    bit ok, got; int cyc;
    rsp_ready = 1'b1; ar_hold = 1'b1;
    send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, ok);
    @(negedge clk);
    checks++;
    if (!ok || {m_axi.arvalid, timeout} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre: accepted=%b arvalid=%b timeout=%b expected 1/1/1", ok, m_axi.arvalid, timeout);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axi.arvalid, m_axi.rready, rsp_valid, timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_async: arvalid=%b rready=%b rsp_valid=%b timeout=%b expected 0000",
               m_axi.arvalid, m_axi.rready, rsp_valid, timeout);
    end
    ar_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, m_axi.arvalid} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_release: cmd_ready/arvalid=%b expected 10", {cmd_ready, m_axi.arvalid});
    end
    send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, ok);
    wait_rsp(got, cyc);
    checks++;
    if (!(ok && got) || {rsp_resp, rsp_rdata} !== {RESP_OKAY, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_recover: done=%b resp=%b rdata=%h expected 1/00/00000000",
               ok && got, rsp_resp, rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_ctrl();
    test_write_read();
    test_aw_stall();
    test_read_error();
    test_timeout();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- Single-outstanding AXI4-Lite initiator. Turns a simple valid/ready command into one register write or read on an AXI-Lite slave port, and returns the data and response on a valid/ready response channel.
- Used by the on-chip sequencer and the testbench to drive the accelerator control/status registers (run/matw/last at 0x00, control at 0x10) without a PS.
- Also reports AXI stalls through a sticky timeout flag.

Parameters:
- ADDR_W, 32, address width of cmd_addr and M_AXI_AWADDR/ARADDR.
- TIMEOUT, 1024, maximum cycles in any wait state before timeout is set; 0 disables the check.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; low 2 bits forwarded unchanged.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- timeout  out  1  sticky stall flag; cleared only by reset.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master signals. Widths are ADDR_W, 32, 4 and 2. AWPROT/ARPROT are tied to 3'b000.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all AXI VALID/READY outputs 0; rsp_valid=0; rsp_* data 0; addr/data registers 0; timeout=0; stall counter 0.
- cmd_ready = (state==IDLE). This is combinational from state only and never depends on cmd_valid.
- All AXI outputs and rsp_* come from registers; there is no combinational path from AXI inputs to AXI outputs.

State machine:
- IDLE:
  - cmd_valid & cmd_write: latch addr/data/strb; next cycle AWVALID=WVALID=1; go WADDR.
  - cmd_valid & !cmd_write: latch addr; ARVALID=1; go RADDR.
- WADDR:
  - AWVALID drops the cycle after the AW handshake; WVALID drops the cycle after the W handshake.
  - Handshakes may complete in either order or the same cycle.
  - Once both are done (aw_done & w_done flags), go WRESP with BREADY=1.
  - VALID is never withdrawn before its handshake.
- WRESP: BREADY=1. On BVALID, capture BRESP, rsp_write=1, rsp_rdata=0, rsp_valid=1; BREADY drops; go RSP.
- RADDR: ARVALID held until ARREADY; then ARVALID=0, RREADY=1; go RDATA.
- RDATA: on RVALID capture RDATA/RRESP, rsp_write=0, rsp_valid=1, RREADY=0; go RSP.
- RSP:
  - rsp_valid held with stable data until rsp_ready; then rsp_valid=0, go IDLE.
  - If rsp_ready is already high on entry, the response is accepted in the first RSP cycle.

Latency and throughput:
- Against a zero-wait slave (AW/W ready in IDLE, B one cycle later): cmd accept at T0, AW/W handshake T1, B at T2, rsp_valid at T3.
- Earliest next cmd_ready is T4 (RSP exit to IDLE).
- One transaction in flight at a time; writes and reads never overlap.

Stall counter:
- Resets to 0 on every state change.
- Increments while in WADDR, WRESP, RADDR or RDATA.
- When TIMEOUT≠0 and the counter reaches TIMEOUT: set timeout=1 and saturate the counter.
- The transaction is never aborted; it waits indefinitely. This keeps the AXI protocol legal.

Boundary conditions:
- BRESP/RRESP ≠ OKAY is reported verbatim; no retry.
- cmd_* changing while cmd_ready=0 is ignored.
- Reset mid-transaction drops all VALIDs immediately, even before their handshake. The slave is reset alongside (shared ARESETN domain).

Decomposition:
- Package axil_pkg:
  - state enum IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - Register offsets REG_CTRL=0x00, REG_CONTROL=0x10.
- Sub-module axil_stall_timer: counter, saturate, sticky flag; inputs clk, rst_n, clear, enable. Everything else stays flat.

Test Plan:
- Write 0x7 to 0x00 against the team's accelerator slave, rsp_ready=1 -> AW/W handshake same cycle; rsp_valid 3 cycles after cmd accept; rsp_resp=00; slave {last,run,matw}=3'b111.
- Write 0xDEADBEEF to 0x10, then read 0x10 -> read rsp_rdata=0xDEADBEEF, rsp_write=0, RRESP=00; ARVALID high exactly 1 cycle.
- Bench slave holds AWREADY low 5 cycles, WREADY high -> W handshakes first, WVALID drops, AWVALID stays high 5 cycles, single B, rsp_resp=00.
- Bench slave returns RRESP=2'b10 with RDATA=0x12345678; rsp_ready low 4 cycles -> rsp_valid held, data stable, cmd_ready=0 until accept.
- TIMEOUT=16, slave never asserts BVALID -> timeout=1 exactly 16 cycles after entering WRESP; BREADY stays 1; late BVALID still completes rsp.
- Assert M_AXI_ARESETN low while ARVALID=1 -> ARVALID, rsp_valid and timeout go 0 asynchronously; after release cmd_ready=1 on the first clock.
